// File: rtl/quad_step_decoder.sv
// Quadrature A/B front end: 2-flop sync, per-channel glitch filter, x4 decode to step/up_down, wrapping position, sticky err.
// Optional index channel enc_z (zeroes position on filtered rising edge) is enabled by defining QUAD_IDX_EN.
module quad_step_decoder #(
  parameter int FILTER_LEN = 3,
  parameter int POS_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ena,
  input  logic                 enc_a,
  input  logic                 enc_b,
`ifdef QUAD_IDX_EN
  input  logic                 enc_z,
`endif
  input  logic                 set,
  input  logic [POS_WIDTH-1:0] set_value,
  input  logic                 err_clr,
  output logic                 step,
  output logic                 up_down,
  output logic [POS_WIDTH-1:0] position,
  output logic                 err
);

`ifdef QUAD_IDX_EN
  localparam int NCH = 3;
`else
  localparam int NCH = 2;
`endif

  localparam logic [3:0]           CNT_LAST   = 4'(FILTER_LEN - 1);
  localparam logic [4:0]           BLANK_INIT = 5'(FILTER_LEN + 2);
  localparam logic [POS_WIDTH-1:0] POS_ONE    = POS_WIDTH'(1);

  // Channel index: 0 = A, 1 = B, 2 = Z (index build only)
  logic [NCH-1:0] raw;
  logic [NCH-1:0] sync1;
  logic [NCH-1:0] sync2;
  logic [NCH-1:0] filt;
  logic [NCH-1:0] prev;
  logic [3:0]     cnt [NCH];
  logic [4:0]     blank;

`ifdef QUAD_IDX_EN
  assign raw = {enc_z, enc_b, enc_a};
`else
  assign raw = {enc_b, enc_a};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      filt  <= '0;
      prev  <= '0;
      blank <= BLANK_INIT;
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      prev  <= filt;
      if (blank != 5'd0) blank <= blank - 5'd1;
      for (int i = 0; i < NCH; i++) begin
        // During blanking the filter is bypassed so filt settles on the encoder's rest state
        if (blank != 5'd0) begin
          filt[i] <= sync2[i];
          cnt[i]  <= '0;
        end else if (sync2[i] == filt[i]) begin
          cnt[i]  <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          filt[i] <= sync2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i]  <= cnt[i] + 4'd1;
        end
      end
    end
  end

  logic [1:0] ab_diff;
  logic       live;
  logic       legal;
  logic       illegal;
  logic       dir;
  logic       step_nxt;
  logic       err_set;
  logic       idx_zero;

  always_comb begin
    ab_diff  = filt[1:0] ^ prev[1:0];
    live     = ena && (blank == 5'd0);
    legal    = ab_diff[0] ^ ab_diff[1];
    illegal  = ab_diff[0] & ab_diff[1];
    // A leads B when going up: new A differs from old B
    dir      = filt[0] ^ prev[1];
    step_nxt = live & legal;
    err_set  = live & illegal;
`ifdef QUAD_IDX_EN
    idx_zero = live & filt[2] & ~prev[2];
`else
    idx_zero = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step     <= 1'b0;
      up_down  <= 1'b0;
      position <= '0;
      err      <= 1'b0;
    end else begin
      step <= step_nxt;
      if (step_nxt) up_down <= dir;
      if (set)
        position <= set_value;
      else if (idx_zero)
        position <= '0;
      else if (step_nxt)
        position <= dir ? position + POS_ONE : position - POS_ONE;
      if (err_set)
        err <= 1'b1;
      else if (err_clr)
        err <= 1'b0;
    end
  end

endmodule
